// File: rtl/alu_exec_if.sv
// Request/result handshake bundle for the execute-stage ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_ctrl;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_err;

    modport master (
        output in_valid, in_ctrl, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_ctrl, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_err
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, shifts iterate one bit per cycle.
// Results are registered and held until the consumer takes them.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  alu_if
);

    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSll = 4'b0011;
    localparam logic [3:0] CtrlSrl = 4'b0100;
    localparam logic [3:0] CtrlSra = 4'b0101;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlNor = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] work_q;
    logic [3:0]      op_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            err_q;

    logic            accept_d;
    logic            is_shift_d;
    logic            illegal_d;
    logic [SHW-1:0]  shamt_d;
    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] shift_d;

    // Combinational result for the incoming request; shift codes only reach this
    // path with a zero shift amount, so they pass operand A straight through.
    always_comb begin
        accept_d   = alu_if.in_valid && alu_if.in_ready;
        shamt_d    = alu_if.in_b[SHW-1:0];
        is_shift_d = 1'b0;
        illegal_d  = 1'b0;
        alu_d      = '0;
        case (alu_if.in_ctrl)
            CtrlAnd: alu_d = alu_if.in_a & alu_if.in_b;
            CtrlOr:  alu_d = alu_if.in_a | alu_if.in_b;
            CtrlAdd: alu_d = alu_if.in_a + alu_if.in_b;
            CtrlSub: alu_d = alu_if.in_a - alu_if.in_b;
            CtrlSlt: alu_d = {{(XLEN-1){1'b0}},
                              ($signed(alu_if.in_a) < $signed(alu_if.in_b))};
            CtrlNor: alu_d = ~(alu_if.in_a | alu_if.in_b);
            CtrlSll, CtrlSrl, CtrlSra: begin
                is_shift_d = 1'b1;
                alu_d      = alu_if.in_a;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        shift_d = work_q;
        case (op_q)
            CtrlSll: shift_d = {work_q[XLEN-2:0], 1'b0};
            CtrlSrl: shift_d = {1'b0, work_q[XLEN-1:1]};
            CtrlSra: shift_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: shift_d = work_q;
        endcase
    end

    // DONE accepts a new request in the same cycle its result is taken,
    // which keeps single-cycle ops flowing at one per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_d) begin
                        if (is_shift_d && (shamt_d != '0)) begin
                            work_q  <= alu_if.in_a;
                            op_q    <= alu_if.in_ctrl;
                            cnt_q   <= shamt_d;
                            state_q <= SHIFT;
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            err_q    <= illegal_d;
                            state_q  <= DONE;
                        end
                    end else if (state_q == DONE && alu_if.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        result_q <= shift_d;
                        zero_q   <= (shift_d == '0);
                        err_q    <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_if.in_ready   = (state_q == IDLE) || ((state_q == DONE) && alu_if.out_ready);
    assign alu_if.out_valid  = (state_q == DONE);
    assign alu_if.out_result = result_q;
    assign alu_if.out_zero   = zero_q;
    assign alu_if.out_err    = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors for every op, shift latency,
// back-to-back issue, result stall and reset during a shift.
module tb_alu_exec;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   failCount;

    alu_exec_if #(.XLEN(32)) alu_if ();

    alu_exec #(.XLEN(32), .SHW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (alu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request, wait for its result, return latency and whether in_ready rose while busy.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, output int lat, output logic readySeen);
        int guard;
        @(negedge clk);
        alu_if.in_ctrl  = ctrl;
        alu_if.in_a     = a;
        alu_if.in_b     = b;
        alu_if.in_valid = 1'b1;
        guard = 0;
        while (!alu_if.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        alu_if.in_valid = 1'b0;
        lat = 1;
        readySeen = 1'b0;
        while (!alu_if.out_valid && lat < 100) begin
            if (alu_if.in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   lat;
    logic readySeen;
    logic sawValid;

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n            = 1'b0;
        alu_if.in_valid  = 1'b0;
        alu_if.in_ctrl   = 4'b0000;
        alu_if.in_a      = '0;
        alu_if.in_b      = '0;
        alu_if.out_ready = 1'b1;

        #22;
        checkOutput("rst_in_ready",  {31'b0, alu_if.in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'b0, alu_if.out_valid}, 32'd0);
        checkOutput("rst_result",    alu_if.out_result,         32'd0);
        checkOutput("rst_zero",      {31'b0, alu_if.out_zero},  32'd0);
        checkOutput("rst_err",       {31'b0, alu_if.out_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{"add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1'b0, 1});
        vecs.push_back('{"sub",      4'b0110, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{"slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 1'b0, 1});
        vecs.push_back('{"slt_pos",  4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b1, 1'b0, 1});
        vecs.push_back('{"nor",      4'b1100, 32'h0,         32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{"and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1});
        vecs.push_back('{"or",       4'b0001, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1'b0, 1'b0, 1});
        vecs.push_back('{"sra31",    4'b0101, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 1'b0, 32});
        vecs.push_back('{"sll0",     4'b0011, 32'h0000_1234, 32'd0,        32'h0000_1234, 1'b0, 1'b0, 1});
        vecs.push_back('{"sll4",     4'b0011, 32'h0000_0001, 32'd4,        32'h0000_0010, 1'b0, 1'b0, 5});
        vecs.push_back('{"srl4",     4'b0100, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1'b0, 5});
        vecs.push_back('{"srl_shamt_mask", 4'b0100, 32'h0000_00F0, 32'h24, 32'h0000_000F, 1'b0, 1'b0, 5});
        vecs.push_back('{"sll_out",  4'b0011, 32'h8000_0001, 32'd1,        32'h0000_0002, 1'b0, 1'b0, 2});
        vecs.push_back('{"illegal_f", 4'b1111, 32'h1234_5678, 32'h1,       32'h0,         1'b1, 1'b1, 1});
        vecs.push_back('{"illegal_8", 4'b1000, 32'hFFFF_FFFF, 32'h1,       32'h0,         1'b1, 1'b1, 1});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, readySeen);
            checkOutput({vecs[i].tag, "_result"}, alu_if.out_result, vecs[i].res);
            checkOutput({vecs[i].tag, "_zero"}, {31'b0, alu_if.out_zero}, {31'b0, vecs[i].zero});
            checkOutput({vecs[i].tag, "_err"},  {31'b0, alu_if.out_err},  {31'b0, vecs[i].err});
            checkOutput({vecs[i].tag, "_latency"}, lat, vecs[i].lat);
            if (vecs[i].lat > 1)
                checkOutput({vecs[i].tag, "_busy_ready"}, {31'b0, readySeen}, 32'd0);
        end

        // Back-to-back single-cycle ops with in_valid held high.
        @(negedge clk);
        alu_if.out_ready = 1'b1;
        alu_if.in_ctrl = 4'b0010; alu_if.in_a = 32'd1; alu_if.in_b = 32'd2; alu_if.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_add_valid", {31'b0, alu_if.out_valid}, 32'd1);
        checkOutput("b2b_add", alu_if.out_result, 32'd3);
        checkOutput("b2b_ready", {31'b0, alu_if.in_ready}, 32'd1);
        alu_if.in_ctrl = 4'b0000; alu_if.in_a = 32'hF0; alu_if.in_b = 32'h3C;
        @(negedge clk);
        checkOutput("b2b_and_valid", {31'b0, alu_if.out_valid}, 32'd1);
        checkOutput("b2b_and", alu_if.out_result, 32'h30);
        alu_if.in_ctrl = 4'b0001; alu_if.in_a = 32'hF0; alu_if.in_b = 32'h0F;
        @(negedge clk);
        checkOutput("b2b_or_valid", {31'b0, alu_if.out_valid}, 32'd1);
        checkOutput("b2b_or", alu_if.out_result, 32'hFF);
        alu_if.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle_valid", {31'b0, alu_if.out_valid}, 32'd0);

        // Consumer stall: result must hold and new requests must be refused.
        alu_if.out_ready = 1'b0;
        applyStimulus(4'b0010, 32'd10, 32'd20, lat, readySeen);
        @(negedge clk);
        alu_if.in_ctrl = 4'b0110; alu_if.in_a = 32'd1; alu_if.in_b = 32'd1; alu_if.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall_valid_%0d", k), {31'b0, alu_if.out_valid}, 32'd1);
            checkOutput($sformatf("stall_result_%0d", k), alu_if.out_result, 32'd30);
            checkOutput($sformatf("stall_ready_%0d", k), {31'b0, alu_if.in_ready}, 32'd0);
            @(negedge clk);
        end
        alu_if.in_valid  = 1'b0;
        alu_if.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_valid", {31'b0, alu_if.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("release_valid_after", {31'b0, alu_if.out_valid}, 32'd0);

        // Reset in the middle of a long shift.
        alu_if.in_ctrl = 4'b0011; alu_if.in_a = 32'h1; alu_if.in_b = 32'd20; alu_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready",  {31'b0, alu_if.in_ready},  32'd1);
        checkOutput("midrst_out_valid", {31'b0, alu_if.out_valid}, 32'd0);
        checkOutput("midrst_result",    alu_if.out_result,         32'd0);
        checkOutput("midrst_zero",      {31'b0, alu_if.out_zero},  32'd0);
        checkOutput("midrst_err",       {31'b0, alu_if.out_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (alu_if.out_valid) sawValid = 1'b1;
        end
        checkOutput("postrst_no_valid", {31'b0, sawValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
